rocc_resp_tracker: RTL and testbench

ROCC_RESP_TRACKER -- requirements
Module: rocc_resp_tracker

---
 rtl/rocc_resp_tracker.sv | 161 ++++++++++++++++
 tb/tb_rocc_resp_tracker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_resp_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rocc_resp_tracker
// Purpose  : Tracks in-order transaction IDs of response-bearing RoCC commands
//            and pairs each accelerator response with the oldest live ID. The
//            pair is presented on a one-entry writeback register. After a
//            flush, responses still owed for flushed commands are absorbed by
//            a drain counter so that they never reach writeback.
// Ports    :
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   flush_i               pipeline flush
//   cmd_fire_i/cmd_xd_i   command accepted / command returns a result
//   cmd_trans_id_i        ID of the accepted command
//   full_o                no further response-bearing command may be accepted
//   resp_valid_i/_data_i  accelerator response; resp_ready_o accepts it
//   wb_valid_o/_trans_id_o/_result_o, wb_ready_i   writeback handshake
//   outstanding_o         live entries in the ID FIFO
//   spurious_o            pulse: response dropped with no owner
//   overflow_o            pulse: push attempted while full
// Revision : 1.0 - initial release
// ============================================================================
module rocc_resp_tracker #(
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         cmd_fire_i,
  input  logic                         cmd_xd_i,
  input  logic [TRANS_ID_BITS-1:0]     cmd_trans_id_i,
  output logic                         full_o,
  input  logic                         resp_valid_i,
  input  logic [63:0]                  resp_data_i,
  output logic                         resp_ready_o,
  output logic                         wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]     wb_trans_id_o,
  output logic [63:0]                  wb_result_o,
  input  logic                         wb_ready_i,
  output logic [$clog2(DEPTH):0]       outstanding_o,
  output logic                         spurious_o,
  output logic                         overflow_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  // One extra bit so that drain + outstanding + push never wraps.
  localparam int c_sum_w = c_cnt_w + 1;

  logic [TRANS_ID_BITS-1:0] r_fifo [DEPTH];
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_cnt_w-1:0]       r_count;
  logic [c_cnt_w-1:0]       r_drain;
  logic                     r_wb_valid;
  logic [TRANS_ID_BITS-1:0] r_wb_id;
  logic [63:0]              r_wb_data;
  logic                     r_spurious;
  logic                     r_overflow;

  logic                     w_full;
  logic                     w_resp_ready;
  logic                     w_push;
  logic                     w_overflow;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_drain_dec;
  logic                     w_spurious;
  logic [c_sum_w-1:0]       w_occupancy;
  logic [c_sum_w-1:0]       w_flush_sum;
  logic [c_cnt_w-1:0]       w_flush_drain;

  always_comb begin
    w_occupancy   = {1'b0, r_count} + {1'b0, r_drain};
    w_full        = (w_occupancy == c_sum_w'(DEPTH));
    w_resp_ready  = ~r_wb_valid | wb_ready_i;

    w_push        = cmd_fire_i & cmd_xd_i & ~w_full;
    w_overflow    = cmd_fire_i & cmd_xd_i & w_full;
    w_accept      = resp_valid_i & w_resp_ready;

    // Owed responses for flushed commands are consumed before any live ID.
    // The head ID comes from registered state only, so an ID pushed this
    // cycle can never be matched by a response in the same cycle.
    w_drain_dec   = w_accept & ~flush_i & (r_drain != '0);
    w_pop         = w_accept & ~flush_i & (r_drain == '0) & (r_count != '0);
    w_spurious    = w_accept & ~flush_i & (r_drain == '0) & (r_count == '0);

    // On flush every live or just-pushed ID becomes an owed response; a
    // response accepted in the flush cycle pays one of them off.
    w_flush_sum   = w_occupancy + c_sum_w'(w_push);
    if (w_accept && (w_flush_sum != '0)) begin
      w_flush_sum = w_flush_sum - c_sum_w'(1);
    end
    if (w_flush_sum > c_sum_w'(DEPTH)) begin
      w_flush_drain = c_cnt_w'(DEPTH);
    end else begin
      w_flush_drain = w_flush_sum[c_cnt_w-1:0];
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= cmd_trans_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drain    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_id    <= '0;
      r_wb_data  <= '0;
      r_spurious <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_spurious <= w_spurious;
      r_overflow <= w_overflow;
      if (flush_i) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_drain    <= w_flush_drain;
        r_wb_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        if (w_drain_dec) begin
          r_drain <= r_drain - c_cnt_w'(1);
        end
        if (w_pop) begin
          r_wb_valid <= 1'b1;
          r_wb_id    <= r_fifo[r_rd_ptr];
          r_wb_data  <= resp_data_i;
        end else if (wb_ready_i) begin
          r_wb_valid <= 1'b0;
        end
      end
    end
  end

  assign full_o        = w_full;
  assign resp_ready_o  = w_resp_ready;
  assign wb_valid_o    = r_wb_valid;
  assign wb_trans_id_o = r_wb_id;
  assign wb_result_o   = r_wb_data;
  assign outstanding_o = r_count;
  assign spurious_o    = r_spurious;
  assign overflow_o    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rocc_resp_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rocc_resp_tracker
// Purpose  : Directed self-checking bench for rocc_resp_tracker (DEPTH=4,
//            TRANS_ID_BITS=3). Expected writebacks are queued when a response
//            that should be written back is driven, and popped when the DUT
//            presents the writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rocc_resp_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        cmd_fire_i;
  logic        cmd_xd_i;
  logic [2:0]  cmd_trans_id_i;
  logic        full_o;
  logic        resp_valid_i;
  logic [63:0] resp_data_i;
  logic        resp_ready_o;
  logic        wb_valid_o;
  logic [2:0]  wb_trans_id_o;
  logic [63:0] wb_result_o;
  logic        wb_ready_i;
  logic [2:0]  outstanding_o;
  logic        spurious_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] data;
  } wb_t;
  wb_t sb[$];

  rocc_resp_tracker #(.DEPTH(4), .TRANS_ID_BITS(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .cmd_fire_i     (cmd_fire_i),
    .cmd_xd_i       (cmd_xd_i),
    .cmd_trans_id_i (cmd_trans_id_i),
    .full_o         (full_o),
    .resp_valid_i   (resp_valid_i),
    .resp_data_i    (resp_data_i),
    .resp_ready_o   (resp_ready_o),
    .wb_valid_o     (wb_valid_o),
    .wb_trans_id_o  (wb_trans_id_o),
    .wb_result_o    (wb_result_o),
    .wb_ready_i     (wb_ready_i),
    .outstanding_o  (outstanding_o),
    .spurious_o     (spurious_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic fire, input logic xd, input logic [2:0] id,
                      input logic rv, input logic [63:0] rd, input logic wbr,
                      input logic fl);
    cmd_fire_i     = fire;
    cmd_xd_i       = xd;
    cmd_trans_id_i = id;
    resp_valid_i   = rv;
    resp_data_i    = rd;
    wb_ready_i     = wbr;
    flush_i        = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [2:0] id);
    step(1'b1, 1'b1, id, 1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic resp(input logic [63:0] d, input logic wbr);
    step(1'b0, 1'b0, 3'd0, 1'b1, d, wbr, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic exp_wb(input logic [2:0] id, input logic [63:0] d);
    wb_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  // Compare the presented writeback against the oldest expectation; pop it
  // only when the handoff is known to be consumed.
  task automatic check_wb(input string tag, input bit do_pop);
    wb_t e;
    chk({tag, "_valid"}, 64'(wb_valid_o), 64'd1);
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb observed=writeback expected=none", tag);
    end
    if (sb.size() != 0) begin
      e = sb[0];
      if (do_pop) void'(sb.pop_front());
      chk({tag, "_id"}, 64'(wb_trans_id_o), 64'(e.id));
      chk({tag, "_data"}, wb_result_o, e.data);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0; cmd_fire_i = 1'b0; cmd_xd_i = 1'b0; cmd_trans_id_i = '0;
    resp_valid_i = 1'b0; resp_data_i = '0; wb_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_wb_id", 64'(wb_trans_id_o), 64'd0);
    chk("rst_wb_result", wb_result_o, 64'd0);
    chk("rst_resp_ready", 64'(resp_ready_o), 64'd1);
    rst_i = 1'b0;
    idle();

    // In-order pairing, one-cycle latency
    push(3'd1); push(3'd2); push(3'd3);
    chk("inorder_out3", 64'(outstanding_o), 64'd3);
    exp_wb(3'd1, 64'hA); resp(64'hA, 1'b1);
    check_wb("inorder_wb1", 1'b1);
    chk("inorder_out2", 64'(outstanding_o), 64'd2);
    exp_wb(3'd2, 64'hB); resp(64'hB, 1'b1);
    check_wb("inorder_wb2", 1'b1);
    exp_wb(3'd3, 64'hC); resp(64'hC, 1'b1);
    check_wb("inorder_wb3", 1'b1);
    chk("inorder_out0", 64'(outstanding_o), 64'd0);
    idle();
    chk("inorder_idle_valid", 64'(wb_valid_o), 64'd0);

    // Command without a result leaves the tracker alone
    step(1'b1, 1'b0, 3'd6, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("noxd_out", 64'(outstanding_o), 64'd0);

    // Fill, overflow, and release
    push(3'd0); push(3'd1); push(3'd2);
    chk("fill_notfull", 64'(full_o), 64'd0);
    push(3'd3);
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_out4", 64'(outstanding_o), 64'd4);
    push(3'd5);
    chk("ovf_pulse", 64'(overflow_o), 64'd1);
    chk("ovf_out4", 64'(outstanding_o), 64'd4);
    idle();
    chk("ovf_pulse_end", 64'(overflow_o), 64'd0);
    exp_wb(3'd0, 64'hD0); resp(64'hD0, 1'b1);
    chk("fill_release", 64'(full_o), 64'd0);
    check_wb("fill_wb0", 1'b1);
    exp_wb(3'd1, 64'hD1); resp(64'hD1, 1'b1); check_wb("fill_wb1", 1'b1);
    exp_wb(3'd2, 64'hD2); resp(64'hD2, 1'b1); check_wb("fill_wb2", 1'b1);
    exp_wb(3'd3, 64'hD3); resp(64'hD3, 1'b1); check_wb("fill_wb3", 1'b1);
    idle();

    // Writeback stall holds data and back-pressures responses
    push(3'd4); push(3'd5);
    exp_wb(3'd4, 64'h44); resp(64'h44, 1'b0);
    check_wb("stall_first", 1'b0);
    chk("stall_ready", 64'(resp_ready_o), 64'd0);
    resp(64'h55, 1'b0);
    check_wb("stall_hold", 1'b0);
    chk("stall_out1", 64'(outstanding_o), 64'd1);
    chk("stall_ready2", 64'(resp_ready_o), 64'd0);
    void'(sb.pop_front());
    exp_wb(3'd5, 64'h55); resp(64'h55, 1'b1);
    check_wb("stall_second", 1'b1);
    idle();
    chk("stall_done_valid", 64'(wb_valid_o), 64'd0);
    chk("stall_done_out", 64'(outstanding_o), 64'd0);

    // Flush: owed responses are drained, only the post-flush ID writes back
    push(3'd5); push(3'd6);
    step(1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("flush_out0", 64'(outstanding_o), 64'd0);
    chk("flush_full", 64'(full_o), 64'd0);
    chk("flush_valid", 64'(wb_valid_o), 64'd0);
    push(3'd7);
    chk("flush_out1", 64'(outstanding_o), 64'd1);
    push(3'd0);
    chk("flush_drain_full", 64'(full_o), 64'd1);
    resp(64'h1, 1'b1);
    chk("drain1_valid", 64'(wb_valid_o), 64'd0);
    chk("drain1_spurious", 64'(spurious_o), 64'd0);
    chk("drain1_out", 64'(outstanding_o), 64'd2);
    resp(64'h2, 1'b1);
    chk("drain2_valid", 64'(wb_valid_o), 64'd0);
    exp_wb(3'd7, 64'h3); resp(64'h3, 1'b1);
    check_wb("drain_wb7", 1'b1);
    exp_wb(3'd0, 64'h4); resp(64'h4, 1'b1);
    check_wb("drain_wb0", 1'b1);
    idle();

    // Spurious responses, including no same-cycle bypass
    resp(64'hEE, 1'b1);
    chk("spur_valid", 64'(wb_valid_o), 64'd0);
    chk("spur_pulse", 64'(spurious_o), 64'd1);
    idle();
    chk("spur_pulse_end", 64'(spurious_o), 64'd0);
    step(1'b1, 1'b1, 3'd2, 1'b1, 64'h99, 1'b1, 1'b0);
    chk("bypass_spur", 64'(spurious_o), 64'd1);
    chk("bypass_out", 64'(outstanding_o), 64'd1);
    chk("bypass_valid", 64'(wb_valid_o), 64'd0);

    // Asynchronous reset with live state
    push(3'd3); push(3'd4);
    exp_wb(3'd2, 64'h77);
    step(1'b1, 1'b1, 3'd6, 1'b1, 64'h77, 1'b0, 1'b0);
    chk("prerst_out3", 64'(outstanding_o), 64'd3);
    check_wb("prerst_wb", 1'b1);
    idle();
    chk("prerst_out3_hold", 64'(outstanding_o), 64'd3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(wb_valid_o), 64'd0);
    chk("arst_out", 64'(outstanding_o), 64'd0);
    chk("arst_full", 64'(full_o), 64'd0);
    chk("arst_wb_id", 64'(wb_trans_id_o), 64'd0);
    chk("arst_wb_result", wb_result_o, 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle();
    resp(64'h12, 1'b1);
    chk("postrst_spur", 64'(spurious_o), 64'd1);
    chk("postrst_valid", 64'(wb_valid_o), 64'd0);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
